// File: rtl/pyrite_vpd_initiator.sv
// rtl/pyrite_vpd_initiator.sv - VPD capability initiator driving the cfg_ext config-extension port
// Runs data write, address/F-flag write, flag polling and data read for one command at a time.
module pyrite_vpd_initiator #(
  parameter logic [7:0] VPD_CAP_OFFSET = 8'hB0,
  parameter logic [7:0] FUNC_NUM       = 8'h00,
  parameter int         CFG_TIMEOUT    = 16,
  parameter int         POLL_INTERVAL  = 8,
  parameter int         POLL_LIMIT     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [14:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        cfg_ext_read_received,
  output logic        cfg_ext_write_received,
  output logic [9:0]  cfg_ext_register_number,
  output logic [7:0]  cfg_ext_function_number,
  output logic [31:0] cfg_ext_write_data,
  output logic [3:0]  cfg_ext_write_byte_enable,
  input  logic [31:0] cfg_ext_read_data,
  input  logic        cfg_ext_read_data_valid
);

  localparam logic [9:0] HDR_REG = {4'b0000, VPD_CAP_OFFSET[7:2]};
  localparam logic [9:0] DAT_REG = HDR_REG + 10'd1;
  localparam int TW = $clog2(CFG_TIMEOUT + 1);
  localparam int GW = $clog2(POLL_INTERVAL + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_DATA, S_HDR_WR, S_POLL_GAP, S_POLL_RD,
    S_POLL_WAIT, S_DAT_RD, S_DAT_WAIT, S_RESP
  } state_t;

  state_t        state_q;
  logic          wr_q;
  logic [14:0]   addr_q;
  logic [GW-1:0] gap_q;
  logic [TW-1:0] wait_q;
  logic [PW-1:0] poll_q;
  logic          cmd_ready_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [31:0]   rsp_rdata_q;
  logic          rd_pulse_q;
  logic          wr_pulse_q;
  logic [9:0]    reg_num_q;
  logic [31:0]   cfg_wdata_q;
  logic [3:0]    cfg_be_q;

  logic [PW-1:0] poll_cnt_d;
  logic [TW-1:0] wait_cnt_d;
  logic          timeout_d;
  logic          flag_done_d;
  logic [14:0]   cmd_addr_d;

  assign poll_cnt_d  = poll_q + 1'b1;
  assign wait_cnt_d  = wait_q + 1'b1;
  assign timeout_d   = (wait_q == TW'(CFG_TIMEOUT));
  // Write completes when the responder clears F, read when it sets F.
  assign flag_done_d = (cfg_ext_read_data[31] != wr_q);
  assign cmd_addr_d  = cmd_addr & 15'h7FFC;

  function automatic logic [31:0] hdr_word(input logic f, input logic [14:0] a);
    return {f, a, 16'h0000};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      gap_q       <= '0;
      wait_q      <= '0;
      poll_q      <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rd_pulse_q  <= 1'b0;
      wr_pulse_q  <= 1'b0;
      reg_num_q   <= '0;
      cfg_wdata_q <= '0;
      cfg_be_q    <= '0;
    end else begin
      rd_pulse_q <= 1'b0;
      wr_pulse_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_ready_q && cmd_valid) begin
            cmd_ready_q <= 1'b0;
            wr_q        <= cmd_write;
            addr_q      <= cmd_addr_d;
            poll_q      <= '0;
            wr_pulse_q  <= 1'b1;
            if (cmd_write) begin
              reg_num_q   <= DAT_REG;
              cfg_wdata_q <= cmd_wdata;
              cfg_be_q    <= 4'hF;
              state_q     <= S_WR_DATA;
            end else begin
              reg_num_q   <= HDR_REG;
              cfg_wdata_q <= hdr_word(1'b0, cmd_addr_d);
              cfg_be_q    <= 4'hC;
              state_q     <= S_HDR_WR;
            end
          end
        end
        S_WR_DATA: begin
          wr_pulse_q  <= 1'b1;
          reg_num_q   <= HDR_REG;
          cfg_wdata_q <= hdr_word(1'b1, addr_q);
          cfg_be_q    <= 4'hC;
          state_q     <= S_HDR_WR;
        end
        S_HDR_WR: begin
          gap_q   <= '0;
          state_q <= S_POLL_GAP;
        end
        S_POLL_GAP: begin
          if (gap_q == GW'(POLL_INTERVAL - 1)) begin
            rd_pulse_q <= 1'b1;
            reg_num_q  <= HDR_REG;
            state_q    <= S_POLL_RD;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_POLL_RD: begin
          wait_q  <= TW'(1);
          state_q <= S_POLL_WAIT;
        end
        S_POLL_WAIT: begin
          if (cfg_ext_read_data_valid) begin
            if (flag_done_d) begin
              if (wr_q) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= '0;
                rsp_err_q   <= 1'b0;
                state_q     <= S_RESP;
              end else begin
                rd_pulse_q <= 1'b1;
                reg_num_q  <= DAT_REG;
                state_q    <= S_DAT_RD;
              end
            end else begin
              poll_q <= poll_cnt_d;
              if (poll_cnt_d == PW'(POLL_LIMIT)) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= '0;
                rsp_err_q   <= 1'b1;
                state_q     <= S_RESP;
              end else begin
                gap_q   <= '0;
                state_q <= S_POLL_GAP;
              end
            end
          end else if (timeout_d) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            wait_q <= wait_cnt_d;
          end
        end
        S_DAT_RD: begin
          wait_q  <= TW'(1);
          state_q <= S_DAT_WAIT;
        end
        S_DAT_WAIT: begin
          if (cfg_ext_read_data_valid) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= cfg_ext_read_data;
            rsp_err_q   <= 1'b0;
            state_q     <= S_RESP;
          end else if (timeout_d) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            wait_q <= wait_cnt_d;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready                 = cmd_ready_q;
  assign rsp_valid                 = rsp_valid_q;
  assign rsp_rdata                 = rsp_rdata_q;
  assign rsp_err                   = rsp_err_q;
  assign cfg_ext_read_received     = rd_pulse_q;
  assign cfg_ext_write_received    = wr_pulse_q;
  assign cfg_ext_register_number   = reg_num_q;
  assign cfg_ext_function_number   = FUNC_NUM;
  assign cfg_ext_write_data        = cfg_wdata_q;
  assign cfg_ext_write_byte_enable = cfg_be_q;

endmodule

// File: doc/pyrite_vpd_initiator.md
Name: pyrite_vpd_initiator

Overview:
- Hardware initiator for the PCIe VPD capability protocol. Turns simple read/write commands into the capability's address/F-flag handshake sequence on the UltraScale+ cfg_ext configuration-extension interface.
- Used as an on-chip self-test and loopback driver for the VPD responder and Pyrite flash register space, with no host involved.
- Owns the complete sequence: data-register write, address/flag write, flag polling, data-register read.

Parameters:
- VPD_CAP_OFFSET, 8'hB0, byte offset of the VPD capability header. Data register is at VPD_CAP_OFFSET+4.
- FUNC_NUM, 8'h00, value driven on cfg_ext_function_number.
- CFG_TIMEOUT, 16, maximum cycles to wait for cfg_ext_read_data_valid after a read pulse.
- POLL_INTERVAL, 8, idle cycles between flag polls.
- POLL_LIMIT, 1024, maximum flag polls before the command is aborted.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = VPD write, 0 = VPD read
- cmd_addr  in  15  VPD byte address; bits [1:0] ignored and driven as 0
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_rdata  out  32  read data; 0 for writes
- rsp_err  out  1  timeout occurred
- cfg_ext_read_received  out  1  one-cycle config read pulse
- cfg_ext_write_received  out  1  one-cycle config write pulse
- cfg_ext_register_number  out  10  dword register number
- cfg_ext_function_number  out  8  equals FUNC_NUM
- cfg_ext_write_data  out  32  config write data
- cfg_ext_write_byte_enable  out  4  config write byte enables
- cfg_ext_read_data  in  32  config read data
- cfg_ext_read_data_valid  in  1  config read data strobe

Behaviour:
- Reset values: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, both cfg_ext pulses=0, register_number=0, write_data=0, byte_enable=0. Reset is asynchronous to these values.
- Reset mid-sequence: the state machine returns to IDLE and the command is dropped with no response.
- Register numbers: HDR = VPD_CAP_OFFSET>>2; DAT = HDR+1.
- Header write format: write_data = {F, addr[14:2], 2'b00, 16'h0}; byte_enable = 4'b1100.
- Write pulses: one cycle each, no completion is expected. register_number, write_data and byte_enable are valid in the pulse cycle.
- Read pulses: one cycle each, then the block waits for read_data_valid.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch cmd_write/cmd_addr/cmd_wdata and go to WR_DATA if writing, else HDR_WR.
  - WR_DATA: write DAT with cmd_wdata, byte_enable=4'hF; go to HDR_WR.
  - HDR_WR: write HDR with F=cmd_write; go to POLL_GAP.
  - POLL_GAP: count POLL_INTERVAL cycles; go to POLL_RD.
  - POLL_RD: read-pulse HDR; go to POLL_WAIT.
  - POLL_WAIT: on read_data_valid, the poll is done when bit31 != cmd_write (write: F cleared; read: F set).
    - Done: write goes to RESP with rdata=0; read goes to DAT_RD.
    - Not done: increment poll count. If count == POLL_LIMIT, go to RESP with err=1; else go to POLL_GAP.
  - DAT_RD: read-pulse DAT; go to DAT_WAIT.
  - DAT_WAIT: on read_data_valid, capture rsp_rdata=cfg_ext_read_data; go to RESP.
  - RESP: rsp_valid=1 with data and err held stable. On rsp_ready, return to IDLE with cmd_ready=1 on the next cycle.
- CFG_TIMEOUT:
  - Each read-wait state counts from the pulse.
  - A strobe arriving on cycle CFG_TIMEOUT is accepted; none by then gives RESP with err=1 and rdata=0.
  - read_data_valid outside a wait state is ignored.
- cmd_ready is low in every state except IDLE; only one command is in flight.
- Fixed costs:
  - Write command, zero-wait responder: minimum 2 pulse cycles before polling.
  - Read command: minimum 1 pulse cycle before polling.
  - Poll count resets per command.

Test Plan:
- Write addr 15'h0010, data 32'hCAFEF00D; model clears F on its 3rd poll.
  - Pulses: DAT wdata CAFEF00D be F, then HDR wdata 32'h8010_0000 be C, then 3 polls at POLL_INTERVAL spacing.
  - Response: rsp_valid, err=0.
- Read addr 15'h004C; model sets F on the 1st poll and returns 32'h0000_2021 on DAT.
  - Pulses: HDR wdata 32'h004C_0000, one poll, DAT read.
  - Response: rsp_rdata=0000_2021, err=0.
- Model never flips the flag, POLL_LIMIT=4 -> exactly 4 poll reads, then rsp_err=1.
- Model never asserts read_data_valid -> rsp_err=1 CFG_TIMEOUT+1 cycles after the first poll pulse.
- Hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0 throughout; accepted on the release cycle.
- Assert rst_n=0 during POLL_WAIT -> all outputs reach reset values asynchronously; a new command after release runs normally.
